// File: rtl/shift_clock_gen.sv
// shift_clock_gen: divides the board clock into a 50%-duty shift clock plus a
// one-cycle shift-enable pulse, with run-time selectable speed levels.
// Level L runs at half-period BASE_HALF >> L. A new level is only adopted at a
// clkout toggle (or while idle), so no runt half-periods are ever produced.
module shift_clock_gen #(
  parameter int BASE_HALF  = 25000000,
  parameter int NUM_LEVELS = 4,
  parameter int CNT_W      = 25,
  parameter int LVL_W      = 2
) (
  input  logic             clkin,
  input  logic             reset,
  input  logic             en,
  input  logic             speed_up,
  input  logic             level_clr,
  output logic             clkout,
  output logic             tick,
  output logic [LVL_W-1:0] level,
  output logic [LVL_W-1:0] active_level,
  output logic             dbg_state
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam logic [LVL_W-1:0] TOP_LVL = LVL_W'(NUM_LEVELS - 1);

  state_t           state;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] half_m1;
  logic             at_toggle;

  // Terminal count (half-period minus one) for the level driving the divider.
  always_comb begin
    half_m1 = '0;
    for (int i = 0; i < NUM_LEVELS; i++) begin
      if (active_level == i[LVL_W-1:0]) begin
        half_m1 = CNT_W'((BASE_HALF >> i) - 1);
      end
    end
  end

  assign at_toggle = (counter == half_m1);
  assign dbg_state = (state == RUN);

  // Run/idle FSM, divider counter, registered clkout/tick and level tracking.
  always_ff @(posedge clkin) begin
    if (reset) begin
      state        <= IDLE;
      counter      <= '0;
      clkout       <= 1'b0;
      tick         <= 1'b0;
      level        <= '0;
      active_level <= '0;
    end else begin
      // Requested level: clear beats step-up; step-up saturates at the top.
      if (level_clr) begin
        level <= '0;
      end else if (speed_up && (level != TOP_LVL)) begin
        level <= level + 1'b1;
      end

      if (!en) begin
        // Idle (or pausing): truncate the period, no tick, adopt level now.
        state        <= IDLE;
        counter      <= '0;
        clkout       <= 1'b0;
        tick         <= 1'b0;
        active_level <= level;
      end else begin
        // The edge that leaves IDLE already counts as enabled edge 1.
        state <= RUN;
        if (at_toggle) begin
          counter      <= '0;
          clkout       <= ~clkout;
          tick         <= ~clkout;
          active_level <= level;
        end else begin
          counter <= counter + 1'b1;
          tick    <= 1'b0;
        end
      end
    end
  end

endmodule

// File: doc/shift_clock_gen.md
Name: shift_clock_gen

Overview:
- Parametrised successor to the fixed shift-clock divider.
- Derives a 50%-duty shift clock (CLKOUT) and a one-cycle shift-enable pulse (TICK) from the 100 MHz board clock CLKIN.
- Supports run-time selectable speed levels, so the ball/LED shifter accelerates as play progresses.
- Sits between the board clock and the LED shift register / game FSM.

Parameters:
- BASE_HALF, 25000000: CLKIN cycles per CLKOUT half-period at level 0 (2 Hz at 100 MHz); must be at least 1.
- NUM_LEVELS, 4: number of speed levels. Level L half-period is BASE_HALF >> L. Requires BASE_HALF >> (NUM_LEVELS-1) >= 1.
- CNT_W, 25: counter width; must hold BASE_HALF-1.
- LVL_W, 2: width of level fields; must satisfy 2**LVL_W >= NUM_LEVELS.

Ports:
- CLKIN  in  1  system clock, 100 MHz, rising-edge.
- RESET  in  1  synchronous, active-high reset.
- EN  in  1  run enable; low holds the generator idle.
- SPEED_UP  in  1  single-cycle request to step up one level.
- LEVEL_CLR  in  1  single-cycle request to return to level 0.
- CLKOUT  out  1  divided shift clock, 50% duty.
- TICK  out  1  one-cycle pulse, high in the cycle CLKOUT rises.
- LEVEL  out  LVL_W  requested (pending) speed level.
- ACTIVE_LEVEL  out  LVL_W  level currently driving the divisor.

Behaviour:
Clocking and reset:
- One clock, CLKIN; every register updates on the rising edge.
- RESET is synchronous and active-high, takes priority over all other inputs, and is honoured mid-period.
- Reset values: counter=0, CLKOUT=0, TICK=0, LEVEL=0, ACTIVE_LEVEL=0, state=IDLE.

States:
- IDLE: counter held at 0, CLKOUT=0, TICK=0. Go to RUN on the edge where EN=1.
- RUN: counter increments each edge. Go to IDLE on any edge where EN=0.
- RUN->IDLE clears the counter and forces CLKOUT=0 on that same edge. This truncates the period; TICK is not generated.

Divider (RUN):
- HALF = BASE_HALF >> ACTIVE_LEVEL.
- Number enabled edges from 1, starting at the first edge with EN=1 sampled after IDLE.
- At the edge where counter == HALF-1: counter <= 0, CLKOUT toggles, and ACTIVE_LEVEL <= LEVEL.
- Otherwise: counter <= counter+1.
- Result: CLKOUT toggles at edges HALF, 2*HALF, ... Period is 2*HALF; first rise is at edge HALF.
- TICK is registered and goes high on the same edge CLKOUT goes 0->1, for exactly one cycle. Its rate equals the CLKOUT frequency.
- HALF == 1 (fastest level): CLKOUT toggles every edge (CLKIN/2), and TICK is high every other cycle.

Level control (active in IDLE and RUN):
- LEVEL_CLR=1: LEVEL <= 0. LEVEL_CLR wins over a simultaneous SPEED_UP.
- SPEED_UP=1 and LEVEL < NUM_LEVELS-1: LEVEL <= LEVEL+1.
- SPEED_UP at the top level: saturates, no change, no wrap.
- LEVEL updates on the edge after the request.
- ACTIVE_LEVEL follows LEVEL only at a toggle boundary, or immediately while in IDLE. No runt or glitch half-periods occur.
- Several requests within one half-period: only the final LEVEL is applied.
- EN low does not clear LEVEL; the speed is retained across pause.

Arithmetic:
- Unsigned throughout.
- The shift is a right shift of the constant by ACTIVE_LEVEL.
- Comparison uses a CNT_W-bit counter; no overflow is possible by the parameter constraints.

Test Plan:
All scenarios use BASE_HALF=8, NUM_LEVELS=4, CNT_W=4, LVL_W=2, and a 10 ns CLKIN period.

1. Basic divide:
   - Stimulus: RESET high 3 cycles, then EN=1.
   - Required: CLKOUT rises at enabled edge 8, falls at edge 16, period 160 ns; TICK high one cycle at edges 8, 24, 40; LEVEL=0.
2. Speed step at boundary:
   - Stimulus: SPEED_UP pulse at enabled edge 3.
   - Required: LEVEL=1 from edge 4; ACTIVE_LEVEL stays 0 until edge 8; then half-period is 4 (next toggles at 12, 16); TICK spacing becomes 8 cycles.
3. Saturation and clear priority:
   - Stimulus: 5 SPEED_UP pulses, then SPEED_UP and LEVEL_CLR together.
   - Required: LEVEL saturates at 3, where CLKOUT toggles every edge and TICK is high every other cycle; the simultaneous pulse gives LEVEL=0, and ACTIVE_LEVEL=0 from the next toggle (half-period 8).
4. Pause:
   - Stimulus: at level 1, EN=0 at enabled edge 6.
   - Required: CLKOUT=0, counter=0, no TICK, LEVEL stays 1; on re-enable, first rise after 4 edges.
5. Reset mid-period:
   - Stimulus: RESET while CLKOUT=1 at level 2.
   - Required: next edge gives CLKOUT=0, TICK=0, LEVEL=ACTIVE_LEVEL=0, state IDLE; on release with EN=1, first rise at edge 8.
6. Idle level change:
   - Stimulus: EN=0, SPEED_UP twice.
   - Required: LEVEL=ACTIVE_LEVEL=2 while idle; on EN=1, first rise at edge 2.
